// File: rtl/conv_encoder_axis_pkg.sv
// Shared limits, code-rate encodings and FSM state type
// for the streaming convolutional encoder.
package conv_encoder_axis_pkg;

  localparam int MAX_CONSTRAINT_LENGTH = 9;
  localparam int MAX_CODE_RATE = 3;

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } enc_state_e;

endpackage

// File: rtl/conv_encoder_axis_core.sv
// Combinational DATA_W-bit unrolled convolutional encoder.
// Shared between data beats and the zero-tail beat.
module conv_enc_core
  import conv_encoder_axis_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MAX_K = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_R = MAX_CODE_RATE,
  parameter int NB_W = $clog2(DATA_W + 1)
) (
  input  logic [MAX_K-2:0]        state,
  input  logic [MAX_K*MAX_R-1:0]  polys,
  input  logic [3:0]              k,
  input  logic                    rate,
  input  logic [DATA_W-1:0]       data,
  input  logic [NB_W-1:0]         nbits,
  output logic [DATA_W*MAX_R-1:0] code,
  output logic [MAX_K-2:0]        next_state
);

  logic [MAX_K-2:0] mask;
  logic [MAX_K-2:0] s;
  logic [MAX_K-1:0] win;
  logic [MAX_R-1:0] c [DATA_W];
  logic [DATA_W*MAX_R-1:0] code2;
  logic [DATA_W*MAX_R-1:0] code3;

  always_comb begin
    mask = '0;
    for (int b = 0; b < MAX_K - 1; b++) begin
      mask[b] = (b < int'(k) - 1);
    end
  end

  always_comb begin
    s = state & mask;
    win = '0;
    c = '{default: '0};
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(nbits)) begin
        win = {s, data[i]};
        for (int j = 0; j < MAX_R; j++) begin
          c[i][j] = ^(polys[j*MAX_K +: MAX_K] & win);
        end
        s = {s[MAX_K-3:0], data[i]} & mask;
      end
    end
    next_state = s;
  end

  // Both packings are built with fixed indices; rate picks one.
  always_comb begin
    code2 = '0;
    code3 = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int j = 0; j < 2; j++) begin
        code2[i*2+j] = c[i][j];
      end
      for (int j = 0; j < 3; j++) begin
        code3[i*3+j] = c[i][j];
      end
    end
    code = (rate == CODE_RATE_3) ? code3 : code2;
  end

endmodule

// File: rtl/conv_encoder_axis.sv
// Frame-based convolutional encoder with ready/valid streams,
// optional zero-tail and chainable trellis state.
module conv_encoder_axis
  import conv_encoder_axis_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MAX_K = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_R = MAX_CODE_RATE
) (
  input  logic                              sys_clk,
  input  logic                              rst,
  input  logic                              i_code_rate,
  input  logic [3:0]                        i_constraint_len,
  input  logic [MAX_K*MAX_R-1:0]            i_gen_poly_flat,
  input  logic                              i_zero_tail,
  input  logic [MAX_K-2:0]                  i_prv_encoder_state,
  input  logic [DATA_W-1:0]                 i_s_tdata,
  input  logic [$clog2(DATA_W+1)-1:0]       i_s_nbits,
  input  logic                              i_s_tvalid,
  input  logic                              i_s_tlast,
  output logic                              o_s_tready,
  output logic [DATA_W*MAX_R-1:0]           o_m_tdata,
  output logic [$clog2(DATA_W*MAX_R+1)-1:0] o_m_nbits,
  output logic                              o_m_tvalid,
  output logic                              o_m_tlast,
  input  logic                              i_m_tready,
  output logic [MAX_K-2:0]                  o_final_state,
  output logic                              o_done
);

  localparam int NB_W = $clog2(DATA_W + 1);
  localparam int ONB_W = $clog2(DATA_W * MAX_R + 1);

  enc_state_e fsm, fsm_nxt;

  logic                   rate_q;
  logic [3:0]             k_q;
  logic [MAX_K*MAX_R-1:0] poly_q;
  logic                   zt_q;
  logic [MAX_K-2:0]       run_st_q;
  logic                   rdy_en_q;

  logic                   rate_c;
  logic [3:0]             k_c;
  logic [MAX_K*MAX_R-1:0] poly_c;
  logic                   zt_c;
  logic [MAX_K-2:0]       st_c;
  logic [DATA_W-1:0]      data_c;
  logic [NB_W-1:0]        nb_c;
  logic [ONB_W-1:0]       nb_x;
  logic [ONB_W-1:0]       onb_c;

  logic [DATA_W*MAX_R-1:0] code;
  logic [MAX_K-2:0]        nxt_st;

  logic out_free, accept, tail_load, load;

  assign out_free = ~o_m_tvalid | i_m_tready;
  assign o_s_tready = rdy_en_q & (fsm != TAIL) & out_free;
  assign accept = i_s_tvalid & o_s_tready;
  assign tail_load = (fsm == TAIL) & out_free;
  assign load = accept | tail_load;

  // A frame's first beat uses the live config; later beats use the latch.
  always_comb begin
    rate_c = rate_q;
    k_c = k_q;
    poly_c = poly_q;
    zt_c = zt_q;
    st_c = run_st_q;
    if (fsm == IDLE) begin
      rate_c = i_code_rate;
      k_c = i_constraint_len;
      poly_c = i_gen_poly_flat;
      zt_c = i_zero_tail;
      st_c = i_prv_encoder_state;
    end
    if (fsm == TAIL) begin
      data_c = '0;
      nb_c = NB_W'(k_q - 4'd1);
    end else begin
      data_c = i_s_tdata;
      nb_c = i_s_tlast ? i_s_nbits : NB_W'(DATA_W);
    end
    nb_x = ONB_W'(nb_c);
    onb_c = (rate_c == CODE_RATE_3) ? nb_x + nb_x + nb_x
                                    : nb_x + nb_x;
  end

  conv_enc_core #(
    .DATA_W(DATA_W),
    .MAX_K (MAX_K),
    .MAX_R (MAX_R),
    .NB_W  (NB_W)
  ) u_core (
    .state     (st_c),
    .polys     (poly_c),
    .k         (k_c),
    .rate      (rate_c),
    .data      (data_c),
    .nbits     (nb_c),
    .code      (code),
    .next_state(nxt_st)
  );

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE: if (accept) begin
        if (!i_s_tlast) fsm_nxt = RUN;
        else fsm_nxt = i_zero_tail ? TAIL : IDLE;
      end
      RUN: if (accept && i_s_tlast) begin
        fsm_nxt = zt_q ? TAIL : IDLE;
      end
      TAIL: if (out_free) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      fsm <= IDLE;
      rdy_en_q <= 1'b0;
      rate_q <= 1'b0;
      k_q <= '0;
      poly_q <= '0;
      zt_q <= 1'b0;
      run_st_q <= '0;
      o_m_tdata <= '0;
      o_m_nbits <= '0;
      o_m_tvalid <= 1'b0;
      o_m_tlast <= 1'b0;
      o_final_state <= '0;
      o_done <= 1'b0;
    end else begin
      fsm <= fsm_nxt;
      rdy_en_q <= 1'b1;
      o_done <= o_m_tvalid & i_m_tready & o_m_tlast;
      if (accept && fsm == IDLE) begin
        rate_q <= i_code_rate;
        k_q <= i_constraint_len;
        poly_q <= i_gen_poly_flat;
        zt_q <= i_zero_tail;
      end
      if (accept) run_st_q <= nxt_st;
      if (accept && i_s_tlast) o_final_state <= nxt_st;
      if (load) begin
        o_m_tdata <= code;
        o_m_nbits <= onb_c;
        o_m_tvalid <= 1'b1;
        o_m_tlast <= tail_load | (i_s_tlast & ~zt_c);
      end else if (i_m_tready) begin
        o_m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_axis.sv
// Randomised bench for conv_encoder_axis against a bit-level
// trellis model, plus directed impulse/tail/chain/reset cases.
module tb_conv_encoder_axis;
  import conv_encoder_axis_pkg::*;

  localparam int DW = 8;
  localparam int MK = 9;
  localparam int MR = 3;
  localparam int NBW = $clog2(DW + 1);
  localparam int ONBW = $clog2(DW * MR + 1);
  localparam int OW = DW * MR;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic i_code_rate = 1'b0;
  logic [3:0] i_constraint_len = 4'd3;
  logic [MK*MR-1:0] i_gen_poly_flat = '0;
  logic i_zero_tail = 1'b0;
  logic [MK-2:0] i_prv_encoder_state = '0;
  logic [DW-1:0] i_s_tdata = '0;
  logic [NBW-1:0] i_s_nbits = '0;
  logic i_s_tvalid = 1'b0;
  logic i_s_tlast = 1'b0;
  logic o_s_tready;
  logic [OW-1:0] o_m_tdata;
  logic [ONBW-1:0] o_m_nbits;
  logic o_m_tvalid, o_m_tlast;
  logic i_m_tready = 1'b1;
  logic [MK-2:0] o_final_state;
  logic o_done;

  conv_encoder_axis #(.DATA_W(DW), .MAX_K(MK), .MAX_R(MR)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_code_rate(i_code_rate),
    .i_constraint_len(i_constraint_len),
    .i_gen_poly_flat(i_gen_poly_flat),
    .i_zero_tail(i_zero_tail),
    .i_prv_encoder_state(i_prv_encoder_state),
    .i_s_tdata(i_s_tdata), .i_s_nbits(i_s_nbits),
    .i_s_tvalid(i_s_tvalid), .i_s_tlast(i_s_tlast),
    .o_s_tready(o_s_tready),
    .o_m_tdata(o_m_tdata), .o_m_nbits(o_m_nbits),
    .o_m_tvalid(o_m_tvalid), .o_m_tlast(o_m_tlast),
    .i_m_tready(i_m_tready),
    .o_final_state(o_final_state), .o_done(o_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: h holds the input history, bit t = input t bits ago.
  function automatic void model_enc(
    input logic [7:0] st, input logic [MK*MR-1:0] polys,
    input int k, input int r, input logic [DW-1:0] d, input int nb,
    output logic [OW-1:0] td, output logic [7:0] ns);
    int h, pos, ones;
    int m1;
    m1 = (1 << (k - 1)) - 1;
    h = int'(st) & m1;
    td = '0;
    pos = 0;
    for (int i = 0; i < nb; i++) begin
      h = ((h & m1) << 1) | int'(d[i]);
      for (int j = 0; j < r; j++) begin
        ones = 0;
        for (int t = 0; t < k; t++)
          if (polys[j*MK+t] && h[t]) ones++;
        td[pos] = ones[0];
        pos++;
      end
    end
    ns = 8'(h & m1);
  endfunction

  // Model state
  bit m_in_frame = 0;
  int m_rate, m_k;
  logic [MK*MR-1:0] m_polys;
  bit m_zt;
  logic [7:0] m_state;
  logic [OW-1:0] q_td[$];
  int q_nb[$];
  bit q_last[$];
  logic [7:0] exp_final = '0;
  logic [OW-1:0] log_td[$];
  int log_nb[$];

  bit prev_rst = 0, prev_hs_last = 0, prev_stall = 0;
  logic [OW-1:0] snap_td;
  logic [ONBW-1:0] snap_nb;
  logic snap_last;

  task automatic model_accept();
    logic [7:0] st, ns, ns2;
    logic [OW-1:0] td, td2;
    int nb;
    if (!m_in_frame) begin
      m_rate = i_code_rate ? 3 : 2;
      m_k = int'(i_constraint_len);
      m_polys = i_gen_poly_flat;
      m_zt = i_zero_tail;
      st = i_prv_encoder_state;
    end else begin
      st = m_state;
    end
    nb = i_s_tlast ? int'(i_s_nbits) : DW;
    model_enc(st, m_polys, m_k, m_rate, i_s_tdata, nb, td, ns);
    q_td.push_back(td);
    q_nb.push_back(nb * m_rate);
    q_last.push_back(i_s_tlast && !m_zt);
    m_state = ns;
    m_in_frame = 1;
    if (i_s_tlast) begin
      exp_final = ns;
      m_in_frame = 0;
      if (m_zt) begin
        model_enc(ns, m_polys, m_k, m_rate, '0, m_k - 1, td2, ns2);
        q_td.push_back(td2);
        q_nb.push_back((m_k - 1) * m_rate);
        q_last.push_back(1'b1);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (prev_rst) begin
      chk("rst_tvalid", 32'(o_m_tvalid), 0);
      chk("rst_tdata", 32'(o_m_tdata), 0);
      chk("rst_nbits", 32'(o_m_nbits), 0);
      chk("rst_tlast", 32'(o_m_tlast), 0);
      chk("rst_final", 32'(o_final_state), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_tready", 32'(o_s_tready), 0);
    end else begin
      chk("done", 32'(o_done), 32'(prev_hs_last));
      chk("final_state", 32'(o_final_state), 32'(exp_final));
      if (prev_stall) begin
        chk("stall_valid", 32'(o_m_tvalid), 1);
        chk("stall_tdata", 32'(o_m_tdata), 32'(snap_td));
        chk("stall_nbits", 32'(o_m_nbits), 32'(snap_nb));
        chk("stall_tlast", 32'(o_m_tlast), 32'(snap_last));
      end
      if (o_m_tvalid && !i_m_tready)
        chk("tready_blocked", 32'(o_s_tready), 0);
    end
    if (rst) begin
      q_td.delete(); q_nb.delete(); q_last.delete();
      m_in_frame = 0;
      exp_final = '0;
      prev_rst = 1;
      prev_hs_last = 0;
      prev_stall = 0;
    end else begin
      prev_rst = 0;
      if (o_m_tvalid && i_m_tready) begin
        log_td.push_back(o_m_tdata);
        log_nb.push_back(int'(o_m_nbits));
        if (q_td.size() == 0) begin
          chk("unexpected_beat", 32'(o_m_tdata), 32'hdeadbeef);
        end else begin
          chk("tdata", 32'(o_m_tdata), 32'(q_td.pop_front()));
          chk("nbits", 32'(o_m_nbits), 32'(q_nb.pop_front()));
          chk("tlast", 32'(o_m_tlast), 32'(q_last.pop_front()));
        end
      end
      prev_hs_last = o_m_tvalid && i_m_tready && o_m_tlast;
      prev_stall = o_m_tvalid && !i_m_tready;
      snap_td = o_m_tdata;
      snap_nb = o_m_nbits;
      snap_last = o_m_tlast;
      if (i_s_tvalid && o_s_tready) model_accept();
    end
  end

  always @(posedge sys_clk) begin
    #1;
    case (rdy_mode)
      0: i_m_tready = 1'b1;
      1: i_m_tready = 1'($urandom % 2);
      default: i_m_tready = 1'b0;
    endcase
  end

  task automatic set_cfg(input logic r, input int k,
                         input logic [MK*MR-1:0] p, input logic zt,
                         input logic [7:0] prv);
    i_code_rate = r;
    i_constraint_len = 4'(k);
    i_gen_poly_flat = p;
    i_zero_tail = zt;
    i_prv_encoder_state = prv;
  endtask

  task automatic send(input logic [DW-1:0] d, input int nb, input bit last);
    int n;
    @(posedge sys_clk); #1;
    i_s_tvalid = 1'b1;
    i_s_tdata = d;
    i_s_nbits = NBW'(nb);
    i_s_tlast = last;
    n = 0;
    forever begin
      @(negedge sys_clk);
      if (o_s_tready) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 32'(n), 0);
        break;
      end
    end
  endtask

  task automatic end_tx();
    @(posedge sys_clk); #1;
    i_s_tvalid = 1'b0;
    i_s_tlast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_td.size() != 0 || o_m_tvalid) && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(q_td.size()), 0);
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    rst = 1'b1;
    i_s_tvalid = 1'b0;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic impulse();
    set_cfg(CODE_RATE_2, 3, {9'd0, 9'b101, 9'b111}, 1'b0, 8'h00);
    send(8'h01, 8, 1);
    end_tx();
    drain();
    chk("impulse_tdata", 32'(log_td[$]), 32'h0037);
    chk("impulse_nbits", 32'(log_nb[$]), 16);
    chk("impulse_final", 32'(o_final_state), 0);
  endtask

  initial begin
    logic [OW-1:0] td, a1, a2, b1, b2;
    logic [7:0] ns, prv;
    logic [DW-1:0] d1, d2;
    logic [MK*MR-1:0] p3, p9, pr;
    int k, nbeats, base;
    bit zt;

    p3 = {9'd0, 9'b101, 9'b111};
    p9 = {9'b100100111, 9'b110011011, 9'b111101101};

    model_enc(8'h00, p3, 3, 2, 8'h01, 8, td, ns);
    chk("model_impulse", 32'(td), 32'h0037);
    chk("model_impulse_st", 32'(ns), 0);
    model_enc(8'h00, p3, 3, 2, 8'h80, 8, td, ns);
    chk("model_msb", 32'(td), 32'hC000);
    chk("model_msb_st", 32'(ns), 1);
    model_enc(8'h01, p3, 3, 2, 8'h00, 2, td, ns);
    chk("model_tail", 32'(td), 32'h000D);

    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge sys_clk);

    impulse();

    set_cfg(CODE_RATE_2, 3, p3, 1'b1, 8'h00);
    send(8'h80, 8, 1);
    end_tx();
    drain();
    chk("zt_data", 32'(log_td[$-1]), 32'hC000);
    chk("zt_data_nb", 32'(log_nb[$-1]), 16);
    chk("zt_tail", 32'(log_td[$]), 32'h000D);
    chk("zt_tail_nb", 32'(log_nb[$]), 4);
    chk("zt_final", 32'(o_final_state), 1);

    d1 = DW'($urandom);
    d2 = DW'($urandom);
    set_cfg(CODE_RATE_3, 9, p9, 1'b0, 8'h52);
    send(d1, 8, 0);
    send(d2, 8, 1);
    end_tx();
    drain();
    a1 = log_td[$-1];
    a2 = log_td[$];
    send(d1, 8, 1);
    end_tx();
    drain();
    b1 = log_td[$];
    set_cfg(CODE_RATE_3, 9, p9, 1'b0, o_final_state);
    send(d2, 8, 1);
    end_tx();
    drain();
    b2 = log_td[$];
    chk("chain_beat1", 32'(b1), 32'(a1));
    chk("chain_beat2", 32'(b2), 32'(a2));

    set_cfg(CODE_RATE_3, 5, {9'b10011, 9'b11101, 9'b10111}, 1'b0, 8'h05);
    send(8'hFF, 3, 1);
    end_tx();
    drain();
    chk("partial_nb", 32'(log_nb[$]), 9);
    chk("partial_msb", 32'(log_td[$] >> 9), 0);

    rdy_mode = 1;
    pr = 27'($urandom) & {9'h07F, 9'h07F, 9'h07F};
    set_cfg(CODE_RATE_3, 7, pr, 1'b1, 8'($urandom));
    base = log_td.size();
    for (int i = 0; i < 16; i++) send(DW'($urandom), 8, i == 15);
    end_tx();
    drain();
    chk("bp_beats", 32'(log_td.size() - base), 17);

    rdy_mode = 2;
    set_cfg(CODE_RATE_2, 3, p3, 1'b0, 8'h00);
    send(8'h5A, 8, 0);
    end_tx();
    do_reset();
    rdy_mode = 0;
    impulse();

    rdy_mode = 2;
    set_cfg(CODE_RATE_2, 3, p3, 1'b1, 8'h00);
    send(8'h80, 8, 1);
    end_tx();
    repeat (3) @(posedge sys_clk);
    do_reset();
    rdy_mode = 0;
    impulse();

    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      k = 3 + int'($urandom % 7);
      pr = '0;
      for (int j = 0; j < MR; j++)
        pr[j*MK +: MK] = 9'($urandom) & 9'((1 << k) - 1);
      zt = 1'($urandom % 2);
      set_cfg(1'($urandom % 2), k, pr, zt, 8'($urandom));
      nbeats = 1 + int'($urandom % 4);
      for (int b = 0; b < nbeats; b++) begin
        if (b == nbeats - 1) send(DW'($urandom), int'($urandom % 9), 1);
        else send(DW'($urandom), 8, 0);
      end
      if ($urandom % 2 == 0) end_tx();
    end
    end_tx();
    drain();
    chk("queue_empty", 32'(q_td.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
